// File: rtl/deco_scan_reg_pkg.sv
// Shared types, defaults and the one-hot helper for the deco_scan_reg decoder slice.
// Imported by the dwell counter and by the top-level decoder.
package deco_pkg;

   localparam int DEF_N     = 4;
   localparam int DEF_DIV_W = 8;
   localparam int MAX_N     = 8;
   localparam int MAX_W     = 1 << MAX_N;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SWEEP  = 2'd2,
      HOLD   = 2'd3
   } state_e;

   // Codes outside 0..2^n-1 give all zeros instead of wrapping onto a real line.
   function automatic logic [MAX_W-1:0] onehot(input int n, input int k);
      logic [MAX_W-1:0] r;
      r = '0;
      if (k >= 0 && k < (1 << n)) begin
         r = MAX_W'(1) << k;
      end
      return r;
   endfunction

endpackage

// File: rtl/deco_dwell_cnt.sv
// Loadable down-counter with stall and zero flag; times how long each sweep code dwells.
module deco_dwell_cnt
   import deco_pkg::*;
#(
   parameter int W = DEF_DIV_W
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         stall_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load wins over counting; the counter parks at zero until it is reloaded.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (!stall_i && cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/deco_scan_reg.sv
// Registered N-to-2^N decoder with a DIRECT handshake mode and a self-running SWEEP mode.
// Define DECO_ACTIVE_LOW_OUT_EN to drive o one-cold (selected line low) instead of one-hot.
module deco_scan_reg
   import deco_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int DIV_W = DEF_DIV_W
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mode,
   input  logic                start,
   input  logic [DIV_W-1:0]    div,
   input  logic [N-1:0]        x,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [(1<<N)-1:0]   o,
   output logic [N-1:0]        code,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                done
);

   localparam int           W    = 1 << N;
   localparam logic [N-1:0] LAST = {N{1'b1}};

   state_e           state_q;
   logic [W-1:0]     o_q;
   logic [N-1:0]     code_q;
   logic [N-1:0]     code_d;
   logic             out_valid_q;
   logic             busy_q;
   logic             done_q;
   logic [DIV_W-1:0] div_q;

   logic             fire;
   logic             accept;
   logic             dwell_zero;
   logic             dwell_load;
   logic [DIV_W-1:0] dwell_val;
   logic             sweep_step;
   logic             sweep_end;

   // The output register frees itself in the same cycle it is drained, so a
   // ready consumer sees a new code every cycle with no bubbles.
   assign in_ready   = (state_q == DIRECT) && (!out_valid_q || out_ready);
   assign fire       = in_valid && in_ready;
   assign accept     = (state_q == SWEEP) && out_valid_q && out_ready;
   assign sweep_step = accept && dwell_zero;
   assign sweep_end  = sweep_step && (code_q == LAST);
   assign code_d     = code_q + N'(1);

   assign dwell_load = ((state_q == IDLE) && mode && start) || (sweep_step && !sweep_end);
   assign dwell_val  = (state_q == IDLE) ? div : div_q;

   deco_dwell_cnt #(.W(DIV_W)) u_dwell (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (dwell_load),
      .load_val_i (dwell_val),
      .stall_i    (!accept),
      .zero_o     (dwell_zero)
   );

   // Main FSM; every output is registered here so o, code and the flags change together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         o_q         <= '0;
         code_q      <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         div_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!mode) begin
                  state_q <= DIRECT;
               end else if (start) begin
                  state_q     <= SWEEP;
                  div_q       <= div;
                  code_q      <= '0;
                  o_q         <= W'(onehot(N, 0));
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            DIRECT: begin
               if (fire) begin
                  o_q         <= W'(onehot(N, int'(x)));
                  code_q      <= x;
                  out_valid_q <= 1'b1;
               end else if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
               end else if (mode && !out_valid_q) begin
                  state_q <= IDLE;
               end
            end
            SWEEP: begin
               // The last code ends the run by terminal compare, never by counter wrap.
               if (sweep_end) begin
                  state_q     <= HOLD;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end else if (sweep_step) begin
                  code_q <= code_d;
                  o_q    <= W'(onehot(N, int'(code_d)));
               end
            end
            HOLD: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef DECO_ACTIVE_LOW_OUT_EN
   assign o = ~o_q;
`else
   assign o = o_q;
`endif

   assign code      = code_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_deco_scan_reg.sv
// Randomised and directed bench for deco_scan_reg, checked against a cycle-level behavioural model.
module tb_deco_scan_reg;

   localparam int N     = 4;
   localparam int DIV_W = 8;
   localparam int W     = 1 << N;

   logic             clk = 1'b0;
   logic             rstN = 1'b1;
   logic             tMode = 1'b0;
   logic             tStart = 1'b0;
   logic [DIV_W-1:0] tDiv = '0;
   logic [N-1:0]     tX = '0;
   logic             tValid = 1'b0;
   logic             tReady = 1'b0;
   logic             inReady;
   logic [W-1:0]     o;
   logic [N-1:0]     code;
   logic             outValid;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0 idle, 1 direct, 2 sweeping, 3 finishing.
   int           mPhase = 0;
   int           mCode = 0;
   int           mLeft = 0;
   int           mDiv = 0;
   logic [W-1:0] mHot = '0;
   logic         mValid = 1'b0;
   logic         mBusy = 1'b0;
   logic         mDone = 1'b0;

   deco_scan_reg #(.N(N), .DIV_W(DIV_W)) dut (
      .clk       (clk),
      .rst_n     (rstN),
      .mode      (tMode),
      .start     (tStart),
      .div       (tDiv),
      .x         (tX),
      .in_valid  (tValid),
      .in_ready  (inReady),
      .o         (o),
      .code      (code),
      .out_valid (outValid),
      .out_ready (tReady),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [W-1:0] expO(input logic [W-1:0] hot);
`ifdef DECO_ACTIVE_LOW_OUT_EN
      return ~hot;
`else
      return hot;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkAll(input string tag);
      logic expRdy;
      expRdy = rstN && (mPhase == 1) && (!mValid || tReady);
      checkOutput({tag, ".o"},        32'(o),        32'(expO(mHot)));
      checkOutput({tag, ".code"},     32'(code),     32'(mCode));
      checkOutput({tag, ".outValid"}, 32'(outValid), 32'(mValid));
      checkOutput({tag, ".inReady"},  32'(inReady),  32'(expRdy));
      checkOutput({tag, ".busy"},     32'(busy),     32'(mBusy));
      checkOutput({tag, ".done"},     32'(done),     32'(mDone));
   endtask

   task automatic modelReset();
      mPhase = 0; mCode = 0; mLeft = 0; mDiv = 0;
      mHot = '0; mValid = 1'b0; mBusy = 1'b0; mDone = 1'b0;
   endtask

   // Each sweep code must be accepted div+1 times before the next one appears.
   task automatic modelStep();
      case (mPhase)
         0: begin
            mDone = 1'b0;
            if (!tMode) begin
               mPhase = 1;
            end else if (tStart) begin
               mPhase = 2; mDiv = int'(tDiv); mCode = 0; mHot = W'(1);
               mValid = 1'b1; mBusy = 1'b1; mLeft = mDiv + 1;
            end
         end
         1: begin
            if (tValid && (!mValid || tReady)) begin
               mHot = W'(1) << tX; mCode = int'(tX); mValid = 1'b1;
            end else if (mValid && tReady) begin
               mValid = 1'b0;
            end else if (tMode && !mValid) begin
               mPhase = 0;
            end
         end
         2: begin
            if (tReady) begin
               mLeft--;
               if (mLeft == 0) begin
                  if (mCode == W - 1) begin
                     mPhase = 3; mValid = 1'b0; mBusy = 1'b0; mDone = 1'b1;
                  end else begin
                     mCode++; mHot = W'(1) << mCode; mLeft = mDiv + 1;
                  end
               end
            end
         end
         default: begin
            mDone = 1'b0; mPhase = 0;
         end
      endcase
   endtask

   task automatic applyStimulus(input logic m, input logic s, input logic [DIV_W-1:0] d,
                                input logic [N-1:0] xx, input logic v, input logic r);
      @(negedge clk);
      tMode = m; tStart = s; tDiv = d; tX = xx; tValid = v; tReady = r;
      #1;
      checkAll("cyc");
      @(posedge clk);
      if (rstN) modelStep();
   endtask

   task automatic doReset();
      @(negedge clk);
      rstN = 1'b0;
      #1;
      modelReset();
      checkAll("rstNow");
      repeat (2) begin
         @(negedge clk);
         #1;
         checkAll("rstHold");
      end
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      modelStep();
   endtask

   logic [N-1:0] streamTbl [16] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC,
                                    4'h5, 4'hA, 4'h7, 4'hE, 4'h9, 4'hB, 4'hD, 4'hF};

   initial begin
      int busyCycles;
      int donePulses;
      int budget;
      int stallLeft;
      logic sawDone;

      // Reset with a valid input pending must not let anything through.
      tValid = 1'b1; tX = 4'h5; tReady = 1'b1;
      doReset();
      for (int i = 0; i < 5 && !mValid; i++) applyStimulus(1'b0, 1'b0, '0, 4'h5, 1'b1, 1'b1);
      #1;
      checkOutput("firstO",    32'(o),    32'(expO(16'h0020)));
      checkOutput("firstCode", 32'(code), 32'd5);

      // Back-to-back direct stream.
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, '0, streamTbl[i], 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, '0, 4'h0, 1'b0, 1'b1);

      // Backpressure holds the output and blocks input.
      applyStimulus(1'b0, 1'b0, '0, 4'hB, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, '0, 4'h2, 1'b1, 1'b0);
         #1;
         checkOutput("bpHoldO",   32'(o),       32'(expO(16'h0800)));
         checkOutput("bpInReady", 32'(inReady), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, '0, 4'h2, 1'b1, 1'b1);
      #1;
      checkOutput("bpNextO", 32'(o), 32'(expO(16'h0004)));

      // Random direct traffic.
      for (int i = 0; i < 200; i++)
         applyStimulus(1'b0, 1'b0, '0, N'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));

      // Leave DIRECT and run a full sweep with div = 2.
      for (int i = 0; i < 10 && mPhase != 0; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput("reachIdle", 32'(mPhase), 32'd0);
      busyCycles = 0; donePulses = 0; sawDone = 1'b0; budget = 0;
      applyStimulus(1'b1, 1'b1, 8'd2, '0, 1'b0, 1'b1);
      #1;
      if (busy) busyCycles++;
      while (!sawDone && budget < 200) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 7) == 0), 8'd2, '0, 1'b0, 1'b1);
         #1;
         if (busy) busyCycles++;
         if (done) begin donePulses++; sawDone = 1'b1; end
         budget++;
      end
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
      #1;
      if (done) donePulses++;
      checkOutput("sweepBusyCycles", 32'(busyCycles), 32'd48);
      checkOutput("sweepDonePulses", 32'(donePulses), 32'd1);

      // Sweep with div = 0: stall at code 7, abort by reset at code 9.
      donePulses = 0; stallLeft = 5; budget = 0;
      applyStimulus(1'b1, 1'b1, 8'd0, '0, 1'b0, 1'b1);
      while (!(mPhase == 2 && mCode == 9) && budget < 100) begin
         if (mCode == 7 && stallLeft > 0) begin
            applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
            stallLeft--;
            #1;
            if (stallLeft == 0) checkOutput("stallCode", 32'(code), 32'd7);
         end else begin
            applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
         end
         #1;
         if (done) donePulses++;
         budget++;
      end
      checkOutput("reachCode9", 32'(mCode), 32'd9);
      doReset();
      #1;
      if (done) donePulses++;
      checkOutput("abortO",          32'(o),          32'(expO(16'h0000)));
      checkOutput("abortDonePulses", 32'(donePulses), 32'd0);

      // Random mix of both modes, sweeps and backpressure.
      tMode = 1'b0;
      for (int i = 0; i < 600; i++) begin
         logic m;
         m = ($urandom_range(0, 19) == 0) ? !tMode : tMode;
         applyStimulus(m, 1'($urandom_range(0, 9) == 0), DIV_W'($urandom_range(0, 2)),
                       N'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
